// File: rtl/simd_pkg.sv
// Shared types and helpers for the SIMD vector datapath blocks.
package simd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Column-major packing: element (r,c) lives at flat index c*N + r.
    function automatic int elem_idx(input int r, input int c, input int n);
        return c * n + r;
    endfunction

    function automatic logic [63:0] sat_reduce(input logic [63:0] acc,
                                               input int unsigned w,
                                               input logic sat);
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        if (sat && (acc > max_v)) begin
            return max_v;
        end
        return acc & max_v;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: unsigned W x W product added into an ACC_W accumulator.
module mac_lane #(
    parameter int W     = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic [ACC_W-1:0] acc_next
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [2*W-1:0]   prod;

    assign prod = {{W{1'b0}}, a_in} * {{W{1'b0}}, b_in};

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // The next value is exported so the owner can register the final sum on the same edge.
    assign acc_next = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiply, C = A x B, one inner-product step per cycle
// across N*N parallel MAC lanes, with valid/ready on both sides.
module matmul_seq
    import simd_pkg::*;
#(
    parameter int BITS_INDEX  = 8,
    parameter int MATRIX_SIZE = 4,
    parameter int WIDTH_V     = 128,
    parameter int ACC_W       = 2 * BITS_INDEX + $clog2(MATRIX_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_V-1:0] a,
    input  logic [WIDTH_V-1:0] b,
    input  logic               sat_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_V-1:0] result,
    output logic               busy
);

    localparam int W  = BITS_INDEX;
    localparam int N  = MATRIX_SIZE;
    localparam int NN = N * N;
    localparam int KW = $clog2(N);

    if (WIDTH_V != NN * W) begin : g_width_check
        $error("matmul_seq: WIDTH_V must equal MATRIX_SIZE*MATRIX_SIZE*BITS_INDEX");
    end

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH_V-1:0] a_q, a_d;
    logic [WIDTH_V-1:0] b_q, b_d;
    logic               sat_q, sat_d;
    logic [WIDTH_V-1:0] result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               clr;
    logic               en;
    logic               capture;

    logic [W-1:0]     a_m      [N][N];
    logic [W-1:0]     b_m      [N][N];
    logic [ACC_W-1:0] acc_next [N][N];

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int E = elem_idx(r, c, N);

            assign a_m[r][c] = a_q[W*(NN-E)-1 -: W];
            assign b_m[r][c] = b_q[W*(NN-E)-1 -: W];

            // Lane (r,c) walks row r of A and column c of B as k advances.
            mac_lane #(
                .W     (W),
                .ACC_W (ACC_W)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (clr),
                .en       (en),
                .a_in     (a_m[r][k_q]),
                .b_in     (b_m[k_q][c]),
                .acc_next (acc_next[r][c])
            );
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        clr         = 1'b0;
        en          = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sat_d   = sat_en;
                    clr     = 1'b1;
                    k_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                en = 1'b1;
                if (k_q == KW'(N - 1)) begin
                    k_d         = '0;
                    capture     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                k_d         = '0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_comb begin
        result_d = result_q;
        if (capture) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    result_d[W*(NN-elem_idx(r, c, N))-1 -: W] =
                        W'(sat_reduce(64'(acc_next[r][c]), W, sat_q));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sat_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sat_q       <= sat_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = !in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequential, parametrised N×N matrix-multiply unit for the SIMD vector datapath: computes C = A×B on packed flat vectors.
- Iterates the inner-product index k over N cycles using N*N parallel MAC lanes.
- Adds a valid/ready handshake on both sides and a wrap/saturate result mode.
- Successor to the combinational 4×4 dot-product block; with default parameters and wrap mode it gives identical results.

Parameters:
- BITS_INDEX, 8, element width W in bits (unsigned).
- MATRIX_SIZE, 4, matrix dimension N (N ≥ 2).
- WIDTH_V, 128, packed vector width; must equal N*N*W (elaboration-time assertion).
- ACC_W, 2*BITS_INDEX+$clog2(MATRIX_SIZE), accumulator width per lane.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b and sat_en are valid.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH_V  matrix A, packed.
- b  input  WIDTH_V  matrix B, packed.
- sat_en  input  1  1 = saturate result elements, 0 = wrap modulo 2^W; sampled at accept.
- out_valid  output  1  result holds a completed product.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH_V  matrix C, packed.
- busy  output  1  high in COMPUTE or DONE.

Behaviour:
- Packing is column-major, MSB-first. Element (r,c) has flat index e = c*N + r and occupies bits [W*(N*N-e)-1 -: W].
- Reset (asynchronous, any state including mid-compute):
  - state = IDLE; k = 0; accumulators = 0; A/B/sat registers = 0.
  - result = 0; out_valid = 0; busy = 0; in_ready = 1 once rst_n is deasserted.
- in_ready = (state == IDLE), a combinational decode of the state register. busy = !in_ready.
- IDLE: on in_valid && in_ready at edge t0:
  - latch a, b, sat_en;
  - clear all accumulators; k = 0;
  - go to COMPUTE.
- In IDLE, in_valid without acceptance has no effect.
- COMPUTE, each edge t1..tN: every lane (r,c) does acc += A[r][k]*B[k][c].
  - Full-precision unsigned arithmetic, no overflow within ACC_W.
  - k increments.
- At edge tN (k == N-1):
  - result is registered from the final accumulator values;
  - out_valid is set; state goes to DONE.
- Latency: out_valid is visible exactly N cycles after the accepting edge. For N = 4, that is the 4th rising edge after t0.
- Result element reduction:
  - wrap: acc[W-1:0];
  - saturate: if acc > 2^W-1 then 2^W-1, else acc[W-1:0].
- DONE: result and out_valid are held stable while out_ready = 0, for any number of cycles.
  - in_valid is ignored; in_ready = 0.
- On out_valid && out_ready: out_valid clears at that edge, state returns to IDLE, and in_ready = 1 the following cycle.
  - result keeps its last value; it is not cleared.
- No overlap between products. Minimum initiation interval is N+2 cycles when out_ready is held at 1.
- Input operands may change freely after acceptance; the latched copies are used.
- An illegal state encoding recovers to IDLE with out_valid = 0.

Decomposition:
- Package simd_pkg holds:
  - state_t enum {IDLE, COMPUTE, DONE};
  - function elem_idx(r,c,N) returning the flat element index;
  - function sat_reduce(acc, W) implementing the wrap/saturate reduction.
- One sub-module: mac_lane (ACC_W accumulator with W×W multiplier, clear, enable). matmul_seq instantiates it N*N times with generate loops.
- Control FSM, k counter and operand/result registers live in matmul_seq.

Test Plan:
- All-2s × all-3s, sat_en=0: result = 16 copies of 8'd24. out_valid rises exactly 4 cycles after the accepting edge, and busy is high throughout.
- A columns {2,1,8,0},{4,5,5,1},{2,2,3,3},{5,6,2,6} × B columns {1,0,4,2},{0,1,1,2},{1,0,4,2},{0,1,1,2} → C columns {20,21,24,24},{16,19,12,16},{20,21,24,24},{16,19,12,16}.
- All-255 × all-255: with sat_en=0 every element = 4 (260100 mod 256); with sat_en=1 every element = 255.
- Hold out_ready=0 for 6 cycles after out_valid while toggling in_valid and a/b:
  - result and out_valid stay stable and in_ready stays 0;
  - raising out_ready clears out_valid at that edge, and in_ready = 1 the next cycle.
- Assert rst_n=0 during the 2nd COMPUTE cycle: result = 0, out_valid = 0 and busy = 0 immediately (asynchronous). After release, a fresh identity × B transaction returns B unchanged.
- Back-to-back transactions with out_ready tied 1 and in_valid held high: each product is correct, and successive acceptances are exactly 6 cycles apart.
